mux_scan_ctrl: RTL and testbench

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

---
 rtl/mux_scan_ctrl.sv | 124 ++++++++++++
 tb/tb_mux_scan_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: sequences a downstream 2:1 mux select through input a and
// then input b. It waits dwell+1 cycles on each input, captures m_out for
// each, and pulses valid once both captures come from the same scan.
// Optional build macro: MUX_SCAN_CONTINUOUS_EN. When it is defined, scans
// repeat back-to-back until abort or rst.
module mux_scan_ctrl #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               m_out,
  output logic               sel,
  output logic               cap_a,
  output logic               cap_b,
  output logic               valid,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLE_A = 2'd1,
    SETTLE_B = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               cap_a_q, cap_a_d;
  logic               cap_b_q, cap_b_d;
  logic               sel_q, sel_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;

  // State, counter, captures and registered outputs; async reset clears all.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dwell_q <= '0;
      cap_a_q <= 1'b0;
      cap_b_q <= 1'b0;
      sel_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      cap_a_q <= cap_a_d;
      cap_b_q <= cap_b_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic. Abort wins over every transition and the counter only
  // loads or decrements from nonzero. Outputs are decoded from the next state
  // so that the registered outputs line up with the state they describe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    cap_a_d = cap_a_q;
    cap_b_d = cap_b_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          dwell_d = dwell;
          cnt_d   = dwell;
          state_d = SETTLE_A;
        end
      end
      SETTLE_A: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          cap_a_d = m_out;
          cnt_d   = dwell_q;
          state_d = SETTLE_B;
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end
      SETTLE_B: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          cap_b_d = m_out;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end
      DONE: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
`ifdef MUX_SCAN_CONTINUOUS_EN
          cnt_d   = dwell_q;
          state_d = SETTLE_A;
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    sel_d   = (state_d == SETTLE_B);
    valid_d = (state_d == DONE);
    busy_d  = (state_d != IDLE);
  end

  assign sel   = sel_q;
  assign cap_a = cap_a_q;
  assign cap_b = cap_b_q;
  assign valid = valid_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: directed scenarios followed by random traffic.
// Every output is compared each cycle against a scan-timeline model.
module tb_mux_scan_ctrl;

  localparam int DWELL_W = 4;

  logic               clk = 1'b0;
  logic               rst, start, abort, m_out;
  logic [DWELL_W-1:0] dwell;
  logic               sel, cap_a, cap_b, valid, busy;
  logic               a_v, b_v;

  int n_chk  = 0;
  int n_fail = 0;
  int vcnt   = 0;

  // Model: the position within the current scan, counted in edges since the
  // edge that accepted start.
  bit m_active;
  int m_e, m_d;
  bit m_cap_a, m_cap_b;

  always #5 clk = ~clk;

  // The downstream 2:1 mux.
  assign m_out = sel ? b_v : a_v;

  mux_scan_ctrl #(.DWELL_W(DWELL_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .dwell(dwell),
    .m_out(m_out), .sel(sel), .cap_a(cap_a), .cap_b(cap_b),
    .valid(valid), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_e = 0; m_d = 0; m_cap_a = 0; m_cap_b = 0;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else if (!m_active) begin
      if (start && !abort) begin
        m_active = 1; m_e = 0; m_d = int'(dwell);
      end
    end else if (abort) begin
      m_active = 0;
    end else begin
      m_e++;
      if (m_e == m_d + 1) m_cap_a = a_v;
      if (m_e == 2 * m_d + 2) m_cap_b = b_v;
      if (m_e == 2 * m_d + 3) begin
`ifdef MUX_SCAN_CONTINUOUS_EN
        m_e = 0;
`else
        m_active = 0;
`endif
      end
    end
  endtask

  task automatic check_all();
    bit e_sel, e_valid;
    e_sel   = m_active && (m_e >= m_d + 1) && (m_e <= 2 * m_d + 1);
    e_valid = m_active && (m_e == 2 * m_d + 2);
    chk("sel",   32'(sel),   32'(e_sel));
    chk("valid", 32'(valid), 32'(e_valid));
    chk("busy",  32'(busy),  32'(m_active));
    chk("cap_a", 32'(cap_a), 32'(m_cap_a));
    chk("cap_b", 32'(cap_b), 32'(m_cap_b));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    if (valid === 1'b1) vcnt++;
    check_all();
  endtask

  task automatic go(input int n);
    repeat (n) cyc();
  endtask

  task automatic do_abort();
    abort = 1'b1; cyc(); abort = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; dwell = '0; a_v = 1'b0; b_v = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0;
    go(2);

    // Single scan with dwell=0: a=1, b=0.
    a_v = 1'b1; b_v = 1'b0; dwell = 4'd0; start = 1'b1; vcnt = 0;
    cyc(); start = 1'b0;
    go(2);
    chk("single_valid", 32'(valid), 32'd1);
    chk("single_cap_a", 32'(cap_a), 32'd1);
    chk("single_cap_b", 32'(cap_b), 32'd0);
    go(2);
    do_abort();
    go(1);

    // dwell=3 with a=0, b=1; changing dwell mid-scan must have no effect.
    a_v = 1'b0; b_v = 1'b1; dwell = 4'd3; start = 1'b1;
    cyc(); start = 1'b0;
    go(3); dwell = 4'd7;
    go(5);
    chk("dwell_valid", 32'(valid), 32'd1);
    chk("dwell_cap_a", 32'(cap_a), 32'd0);
    chk("dwell_cap_b", 32'(cap_b), 32'd1);
    go(3);
    do_abort();

    // Abort in SETTLE_B after a scan that left both captures at 1.
    a_v = 1'b1; b_v = 1'b1; dwell = 4'd2; start = 1'b1;
    cyc(); start = 1'b0;
    go(7);
    do_abort();
    b_v = 1'b0; start = 1'b1;
    cyc(); start = 1'b0;
    go(3);
    chk("abort_pre_sel", 32'(sel), 32'd1);
    vcnt = 0;
    do_abort();
    go(3);
    chk("abort_cap_a", 32'(cap_a), 32'd1);
    chk("abort_cap_b", 32'(cap_b), 32'd1);
    chk("abort_busy",  32'(busy),  32'd0);
    chk("abort_no_valid", 32'(vcnt), 32'd0);

    // start pulsed during SETTLE_A must not restart the scan.
    a_v = 1'b1; b_v = 1'b0; dwell = 4'd2; vcnt = 0; start = 1'b1;
    cyc(); start = 1'b0;
    cyc(); start = 1'b1;
    cyc(); start = 1'b0;
    go(4);
    chk("busy_start_vcnt", 32'(vcnt), 32'd1);
    do_abort();

    // start and abort together in IDLE: stay idle.
    start = 1'b1; abort = 1'b1;
    cyc(); start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", 32'(busy), 32'd0);

    // Mode check with dwell=1: one pulse, or one every 5 cycles.
    dwell = 4'd1; vcnt = 0; start = 1'b1;
    cyc(); start = 1'b0;
    go(16);
`ifdef MUX_SCAN_CONTINUOUS_EN
    chk("mode_vcnt", 32'(vcnt), 32'd3);
`else
    chk("mode_vcnt", 32'(vcnt), 32'd1);
    chk("mode_busy", 32'(busy), 32'd0);
`endif
    do_abort();

    // Reset asserted mid-SETTLE_B with dwell=3.
    a_v = 1'b1; b_v = 1'b1; dwell = 4'd3; start = 1'b1;
    cyc(); start = 1'b0;
    go(5);
    chk("rst_pre_sel", 32'(sel), 32'd1);
    #3 rst = 1'b1;
    #1 model_reset();
    check_all();
    cyc();
    @(negedge clk); rst = 1'b0;
    go(3);
    chk("rst_post_busy", 32'(busy), 32'd0);

    // Random traffic.
    repeat (400) begin
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 15) == 0);
      dwell = DWELL_W'($urandom);
      a_v   = 1'($urandom);
      b_v   = 1'($urandom);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
